// File: rtl/bram_sector_sequencer.sv
// -----------------------------------------------------------------------------
// bram_sector_sequencer
//
// Moves a backup-RAM image to or from the SD card as a burst of 2^SECT_BITS
// sector transfers over the hps_io sd_rd/sd_wr/sd_ack handshake. A rising
// edge on load_req or save_req (with bk_ena high) starts one operation on the
// slot presented at that moment. Each sector is requested, then acknowledged
// by sd_ack rising, then completed by sd_ack falling. A sector that is not
// acknowledged within TIMEOUT cycles aborts the operation, as does bk_ena
// dropping mid-operation.
//
// Optional feature: define BK_AUTOSAVE_EN to track unsaved BRAM writes in
// 'dirty' and start a save on a rising autosave_tick.
//
// Ports
//   clk_sys, reset_n      clock, asynchronous active-low reset
//   bk_ena                writable save image mounted
//   load_req, save_req    request levels (rising edge starts an op)
//   slot                  slot select, captured when an op starts
//   sd_lba                sector address driven to hps_io
//   sd_rd, sd_wr          sector read / write request (never both high)
//   sd_ack                hps_io acknowledge, high for a whole sector
//   bk_loading            load in progress (hold the system in reset)
//   busy                  an operation is in progress
//   done, err             one-cycle completion / abort pulses
//   bram_we_sys           system BRAM write strobe (autosave build only)
//   autosave_tick         autosave trigger level (autosave build only)
//   dirty                 unsaved BRAM changes (constant 0 without autosave)
// -----------------------------------------------------------------------------
module bram_sector_sequencer #(
  parameter int          SECT_BITS = 7,
  parameter int          SLOT_BITS = 2,
  parameter logic [23:0] TIMEOUT   = 24'd5000000
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 bk_ena,
  input  logic                 load_req,
  input  logic                 save_req,
  input  logic [SLOT_BITS-1:0] slot,
  output logic [31:0]          sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  output logic                 bk_loading,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 bram_we_sys,
  input  logic                 autosave_tick,
  output logic                 dirty
);

  localparam int LBA_PAD = 32 - SLOT_BITS - SECT_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t      state;
  logic        op_load;
  logic [23:0] timer;
  logic        old_ack;
  logic        old_load;
  logic        old_save;

  logic load_rise;
  logic save_rise;
  logic ack_rise;
  logic ack_fall;
  logic start_load;
  logic start_save;
  logic start_auto;
  logic start_any;
  logic last_sector;
  logic finish;

  assign load_rise   = load_req & ~old_load;
  assign save_rise   = save_req & ~old_save;
  assign ack_rise    = sd_ack & ~old_ack;
  assign ack_fall    = ~sd_ack & old_ack;
  // Load takes priority when both requests rise in the same cycle.
  assign start_load  = bk_ena & load_rise;
  assign start_save  = bk_ena & save_rise & ~load_rise;
  assign start_any   = (state == IDLE) & (start_load | start_save | start_auto);
  assign last_sector = &sd_lba[SECT_BITS-1:0];
  assign finish      = (state == XFER) & bk_ena & ack_fall & last_sector;

`ifdef BK_AUTOSAVE_EN
  logic old_tick;
  logic tick_rise;

  assign tick_rise  = autosave_tick & ~old_tick;
  // Autosave only fires when no manual request edge is present this cycle.
  assign start_auto = bk_ena & dirty & tick_rise & ~load_rise & ~save_rise;

  // Dirty tracking: cleared when a save starts or a load completes.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dirty    <= 1'b0;
      old_tick <= 1'b1;
    end else begin
      old_tick <= autosave_tick;
      if (start_any && !start_load) begin
        dirty <= 1'b0;
      end else if (finish && op_load) begin
        dirty <= 1'b0;
      end else if (bram_we_sys && !bk_loading) begin
        dirty <= 1'b1;
      end else begin
        dirty <= dirty;
      end
    end
  end
`else
  logic unused_inputs;

  assign start_auto    = 1'b0;
  assign dirty         = 1'b0;
  assign unused_inputs = &{1'b0, bram_we_sys, autosave_tick};
`endif

  // Sector sequencing FSM; all handshake and status outputs are registered.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      op_load    <= 1'b0;
      timer      <= 24'd0;
      old_ack    <= 1'b0;
      old_load   <= 1'b1;
      old_save   <= 1'b1;
      sd_lba     <= 32'd0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      bk_loading <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      old_ack  <= sd_ack;
      old_load <= load_req;
      old_save <= save_req;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (start_any) begin
            op_load    <= start_load;
            sd_lba     <= {{LBA_PAD{1'b0}}, slot, {SECT_BITS{1'b0}}};
            sd_rd      <= start_load;
            sd_wr      <= ~start_load;
            bk_loading <= start_load;
            busy       <= 1'b1;
            timer      <= 24'd0;
            state      <= REQ;
          end else begin
            busy <= 1'b0;
          end
        end
        REQ: begin
          // Abort takes effect the same cycle: outputs drop, err pulses.
          if (!bk_ena || (!ack_rise && (timer == (TIMEOUT - 24'd1)))) begin
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            bk_loading <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b1;
            state      <= IDLE;
          end else if (ack_rise) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= XFER;
          end else begin
            timer <= timer + 24'd1;
          end
        end
        XFER: begin
          if (!bk_ena) begin
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            bk_loading <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b1;
            state      <= IDLE;
          end else if (finish) begin
            bk_loading <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end else if (ack_fall) begin
            // Only the sector field advances; the slot bits never carry.
            sd_lba[SECT_BITS-1:0] <= sd_lba[SECT_BITS-1:0] + SECT_BITS'(1);
            sd_rd                 <= op_load;
            sd_wr                 <= ~op_load;
            timer                 <= 24'd0;
            state                 <= REQ;
          end else begin
            state <= XFER;
          end
        end
        default: begin
          sd_rd      <= 1'b0;
          sd_wr      <= 1'b0;
          bk_loading <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_sector_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for bram_sector_sequencer. An hps_io-like acknowledge model
// answers each sector request; the expected sector address sequence for an
// operation is simply slot*128 + 0..127 in the requested direction.
// -----------------------------------------------------------------------------
module tb_bram_sector_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bk_ena;
  logic        load_req;
  logic        save_req;
  logic [1:0]  slot;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic        bk_loading;
  logic        busy;
  logic        done;
  logic        err;
  logic        bram_we_sys;
  logic        autosave_tick;
  logic        dirty;

  always #5 clk = ~clk;

  bram_sector_sequencer #(
    .SECT_BITS(7),
    .SLOT_BITS(2),
    .TIMEOUT  (24'd16)
  ) dut (
    .clk_sys      (clk),
    .reset_n      (reset_n),
    .bk_ena       (bk_ena),
    .load_req     (load_req),
    .save_req     (save_req),
    .slot         (slot),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .bk_loading   (bk_loading),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .bram_we_sys  (bram_we_sys),
    .autosave_tick(autosave_tick),
    .dirty        (dirty)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Acknowledge model control.
  bit ack_on   = 1'b1;
  bit ack_rand = 1'b0;

  // Observation state, refreshed each falling edge by sample().
  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];
  int  done_n, err_n, overlap_n, rd_hi_n;
  bit  prev_rd = 1'b0;
  bit  prev_wr = 1'b0;

  typedef struct {
    bit          req_load;
    bit          req_save;
    logic [1:0]  slot;
    bit          mid_save;
    bit          kill;
    bit          exp_load;
    logic [31:0] exp_base;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_monitor();
    rd_q.delete();
    wr_q.delete();
    done_n    = 0;
    err_n     = 0;
    overlap_n = 0;
    rd_hi_n   = 0;
    prev_rd   = sd_rd;
    prev_wr   = sd_wr;
  endtask

  task automatic sample();
    if (sd_rd && !prev_rd) rd_q.push_back(sd_lba);
    if (sd_wr && !prev_wr) wr_q.push_back(sd_lba);
    if (sd_rd && sd_wr) overlap_n++;
    if (sd_rd) rd_hi_n++;
    if (done) done_n++;
    if (err) err_n++;
    prev_rd = sd_rd;
    prev_wr = sd_wr;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample();
    end
  endtask

  // hps_io model: after a request is seen, raise ack after a delay, hold it,
  // then drop it to finish the sector.
  initial begin
    int d;
    int h;
    sd_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_on && (sd_rd || sd_wr)) begin
        d = ack_rand ? int'($urandom_range(1, 8)) : 3;
        h = ack_rand ? int'($urandom_range(1, 8)) : 8;
        repeat (d - 1) @(negedge clk);
        sd_ack = 1'b1;
        repeat (h) @(negedge clk);
        sd_ack = 1'b0;
      end
    end
  end

  // Starts one operation at a falling edge and follows it to done/err.
  task automatic run_op(input vec_t v, input string tag);
    int cyc;
    int load_err;
    int seq_err;
    int n_rd;
    int n_wr;
    reset_monitor();
    slot     = v.slot;
    load_req = v.req_load;
    save_req = v.req_save;
    @(negedge clk);
    sample();
    check({tag, "_start_rd"}, sd_rd, v.exp_load);
    check({tag, "_start_wr"}, sd_wr, !v.exp_load);
    check({tag, "_start_lba"}, sd_lba, v.exp_base);
    load_err = 0;
    cyc      = 0;
    while (done_n == 0 && err_n == 0 && cyc < 5000) begin
      if (bk_loading !== v.exp_load) load_err++;
      cyc++;
      if (v.mid_save && cyc == 40) save_req = 1'b0;
      if (v.mid_save && cyc == 50) save_req = 1'b1;
      if (v.kill && cyc == 300) bk_ena = 1'b0;
      @(negedge clk);
      sample();
    end
    if (bk_loading !== 1'b0) load_err++;
    check({tag, "_in_budget"}, cyc < 5000, 1);
    check({tag, "_loading"}, load_err, 0);
    check({tag, "_rd_wr_overlap"}, overlap_n, 0);
    if (v.kill) begin
      check({tag, "_err_n"}, err_n, 1);
      check({tag, "_done_n"}, done_n, 0);
    end else begin
      seq_err = 0;
      if (v.exp_load) begin
        for (int i = 0; i < rd_q.size(); i++)
          if (rd_q[i] !== v.exp_base + 32'(i)) seq_err++;
      end else begin
        for (int i = 0; i < wr_q.size(); i++)
          if (wr_q[i] !== v.exp_base + 32'(i)) seq_err++;
      end
      check({tag, "_done_n"}, done_n, 1);
      check({tag, "_err_n"}, err_n, 0);
      check({tag, "_sectors"}, v.exp_load ? rd_q.size() : wr_q.size(), 128);
      check({tag, "_wrong_dir"}, v.exp_load ? wr_q.size() : rd_q.size(), 0);
      check({tag, "_lba_order"}, seq_err, 0);
      check({tag, "_lba_hold"}, sd_lba, v.exp_base + 32'd127);
    end
    n_rd     = rd_q.size();
    n_wr     = wr_q.size();
    load_req = 1'b0;
    save_req = 1'b0;
    bk_ena   = 1'b1;
    idle_cycles(20);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_no_extra"}, rd_q.size() + wr_q.size(), n_rd + n_wr);
  endtask

  initial begin
    vec_t v;
    int   r;
    int   cyc;

    reset_n       = 1'b0;
    bk_ena        = 1'b1;
    load_req      = 1'b0;
    save_req      = 1'b0;
    slot          = 2'd0;
    bram_we_sys   = 1'b0;
    autosave_tick = 1'b0;

    // Directed table: {req_load, req_save, slot, mid_save, kill, exp_load, exp_base}
    tbl[0] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h100};
    tbl[1] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 32'h000};
    tbl[2] = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 32'h080};
    tbl[3] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 32'h180};
    tbl[4] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 32'h080};
    tbl[5] = '{1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 32'h180};

    repeat (3) @(negedge clk);
    check("reset_outputs", {sd_rd, sd_wr, bk_loading, busy, done, err, dirty}, 0);
    check("reset_lba", sd_lba, 0);
    reset_n = 1'b1;
    idle_cycles(3);

    for (int i = 0; i < 6; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Randomized operations against the address-sequence model.
    ack_rand = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r          = int'($urandom_range(0, 2));
      v.req_load = (r != 1);
      v.req_save = (r != 0);
      v.slot     = 2'($urandom_range(0, 3));
      v.mid_save = 1'b0;
      v.kill     = 1'b0;
      v.exp_load = (r != 1);
      v.exp_base = 32'(v.slot) * 32'd128;
      run_op(v, $sformatf("rnd%0d", i));
    end
    ack_rand = 1'b0;

    // Request edge while bk_ena is low is dropped.
    reset_monitor();
    bk_ena   = 1'b0;
    load_req = 1'b1;
    idle_cycles(5);
    check("noena_busy", busy, 0);
    check("noena_rd", rd_q.size(), 0);
    load_req = 1'b0;
    bk_ena   = 1'b1;
    idle_cycles(3);

    // Ack never arrives: request held for TIMEOUT cycles, then abort.
    ack_on = 1'b0;
    reset_monitor();
    slot     = 2'd0;
    load_req = 1'b1;
    cyc      = 0;
    while (err_n == 0 && done_n == 0 && cyc < 100) begin
      @(negedge clk);
      sample();
      cyc++;
    end
    check("to_rd_cycles", rd_hi_n, 16);
    check("to_err_n", err_n, 1);
    check("to_done_n", done_n, 0);
    check("to_rd_low", sd_rd, 0);
    check("to_busy", busy, 0);
    check("to_loading", bk_loading, 0);
    check("to_lba", sd_lba, 0);
    load_req = 1'b0;
    ack_on   = 1'b1;
    idle_cycles(3);

    // Asynchronous reset during sector 40 of a load; held request must not restart.
    reset_monitor();
    slot     = 2'd0;
    load_req = 1'b1;
    cyc      = 0;
    while (rd_q.size() < 41 && cyc < 5000) begin
      @(negedge clk);
      sample();
      cyc++;
    end
    check("rst_reached", rd_q.size(), 41);
    #2 reset_n = 1'b0;
    #1;
    check("rst_outputs", {sd_rd, sd_wr, bk_loading, busy, done, err, dirty}, 0);
    check("rst_lba", sd_lba, 0);
    @(negedge clk);
    reset_n = 1'b1;
    reset_monitor();
    idle_cycles(10);
    check("rst_stay_idle", busy, 0);
    check("rst_no_req", rd_q.size() + wr_q.size(), 0);
    load_req = 1'b0;
    idle_cycles(20);

`ifdef BK_AUTOSAVE_EN
    // BRAM write marks dirty; tick rise saves to the current slot.
    bram_we_sys = 1'b1;
    @(negedge clk);
    bram_we_sys = 1'b0;
    @(negedge clk);
    check("auto_dirty_set", dirty, 1);
    reset_monitor();
    slot          = 2'd1;
    autosave_tick = 1'b1;
    @(negedge clk);
    sample();
    check("auto_start_wr", sd_wr, 1);
    check("auto_start_lba", sd_lba, 32'h080);
    check("auto_dirty_clr", dirty, 0);
    cyc = 0;
    while (done_n == 0 && err_n == 0 && cyc < 5000) begin
      @(negedge clk);
      sample();
      cyc++;
    end
    check("auto_sectors", wr_q.size(), 128);
    check("auto_done", done_n, 1);
    autosave_tick = 1'b0;
    idle_cycles(20);
`else
    // Without autosave, write strobes and ticks never start anything.
    reset_monitor();
    bram_we_sys = 1'b1;
    @(negedge clk);
    sample();
    bram_we_sys   = 1'b0;
    autosave_tick = 1'b1;
    idle_cycles(10);
    check("noauto_busy", busy, 0);
    check("noauto_req", rd_q.size() + wr_q.size(), 0);
    check("noauto_dirty", dirty, 0);
    autosave_tick = 1'b0;
    idle_cycles(3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
